// File: rtl/fdc_host_arbiter_pkg.sv
// Shared types for the floppy host arbiter.
// Op codes, FSM states, CHS layout and host command word.
package fdc_host_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_SEEK  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } fdc_op_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } fdc_state_e;

  localparam int CYL_W = 7;
  localparam int SEC_W = 8;
  localparam int CHS_W = 1 + CYL_W + SEC_W;

  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd8000000;

  typedef struct packed {
    logic             head;
    logic [CYL_W-1:0] cyl;
    logic [SEC_W-1:0] sector;
  } chs_t;

  // Top two bits are unused and always zero.
  typedef struct packed {
    logic [1:0] rsvd;
    logic [1:0] drive;
    fdc_op_e    op;
    chs_t       chs;
  } host_cmd_t;

endpackage

// File: rtl/fdc_rr_arb2.sv
// Two-way pick: round-robin against the last-served
// pointer, or fixed priority with requester 0 first.
module fdc_rr_arb2 #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (RR_ENABLE && !last) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/fdc_host_arbiter.sv
// Arbitrates two drive requesters onto a single
// host MCU command channel with timeout and ack-of-ack.
module fdc_host_arbiter
  import fdc_host_arbiter_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter bit          RR_ENABLE      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_chs,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [21:0] host_cmd,
  output logic        host_busy,
  input  logic        host_done,
  input  logic        host_err,
  output logic        host_ack2,
  output logic [1:0]  grant
);

  fdc_state_e  state;
  logic [23:0] tmo;
  logic        last;
  logic [1:0]  pick;
  logic [1:0]  op_sel;
  logic [15:0] chs_sel;
  host_cmd_t   cmd_q;

  fdc_rr_arb2 #(
    .RR_ENABLE(RR_ENABLE)
  ) u_arb (
    .req (req_valid),
    .last(last),
    .gnt (pick)
  );

  assign op_sel   = pick[1] ? req_op[3:2]    : req_op[1:0];
  assign chs_sel  = pick[1] ? req_chs[31:16] : req_chs[15:0];
  assign host_cmd = cmd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmo       <= '0;
      last      <= 1'b1;
      grant     <= 2'b00;
      cmd_q     <= '0;
      host_busy <= 1'b0;
      host_ack2 <= 1'b0;
      req_done  <= 2'b00;
      req_err   <= 2'b00;
    end else begin
      req_done <= 2'b00;
      req_err  <= 2'b00;
      unique case (state)
        S_IDLE: begin
          // A stale host_done blocks any new grant.
          if (|req_valid && !host_done) begin
            grant <= pick;
            cmd_q <= {2'b00, pick, op_sel, chs_sel};
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_q.op == OP_RSVD) begin
            req_done <= grant;
            req_err  <= grant;
            last     <= grant[1];
            state    <= S_RELEASE;
          end else begin
            host_busy <= 1'b1;
            tmo       <= TIMEOUT_CYCLES;
            state     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (host_done || tmo == '0) begin
            req_done  <= grant;
            req_err   <= host_done ? (grant & {2{host_err}}) : grant;
            host_busy <= 1'b0;
            host_ack2 <= 1'b1;
            last      <= grant[1];
            state     <= S_RELEASE;
          end else begin
            tmo <= tmo - 24'd1;
          end
        end
        S_RELEASE: begin
          if (!host_done) begin
            host_ack2 <= 1'b0;
            grant     <= 2'b00;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdc_host_arbiter.sv
// Randomized bench for fdc_host_arbiter against a
// transaction-level model of arbitration and host timing.
module tb_fdc_host_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_chs;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [21:0] host_cmd;
  logic        host_busy;
  logic        host_done;
  logic        host_err;
  logic        host_ack2;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;
  int last_served = 1;
  logic [1:0]  op_q [2];
  logic [15:0] chs_q [2];

  fdc_host_arbiter #(
    .TIMEOUT_CYCLES(24'(TMO)),
    .RR_ENABLE(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_chs  (req_chs),
    .req_done (req_done),
    .req_err  (req_err),
    .host_cmd (host_cmd),
    .host_busy(host_busy),
    .host_done(host_done),
    .host_err (host_err),
    .host_ack2(host_ack2),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int r, input logic [1:0] op,
                         input logic [15:0] chs);
    op_q[r] = op;
    chs_q[r] = chs;
    req_op[2*r +: 2] = op;
    req_chs[16*r +: 16] = chs;
    req_valid[r] = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"},
        {10'd0, req_done, req_err, host_busy, host_ack2, grant},
        32'd0);
    chk({tag, "_cmd"}, {10'd0, host_cmd}, 32'd0);
  endtask

  // k: cycles after host_busy is seen before host_done rises
  // (beyond the timeout window means the host never answers).
  task automatic run_txn(input int k, input bit herr, input int hold,
                         input bit drop_early);
    int w;
    int done_t;
    bit exp_err;
    logic [1:0] oh;
    logic [21:0] exp_cmd;
    w = (req_valid == 2'b11) ? 1 - last_served : (req_valid[1] ? 1 : 0);
    oh = 2'b01 << w;
    exp_cmd = {2'b00, oh, op_q[w], chs_q[w]};
    tick();
    chk("grant", {30'd0, grant}, {30'd0, oh});
    chk("cmd", {10'd0, host_cmd}, {10'd0, exp_cmd});
    chk("busy_early", {31'd0, host_busy}, 32'd0);
    tick();
    if (op_q[w] == 2'd3) begin
      chk("rsvd_busy", {31'd0, host_busy}, 32'd0);
      chk("rsvd_done", {30'd0, req_done}, {30'd0, oh});
      chk("rsvd_err", {30'd0, req_err}, {30'd0, oh});
      req_valid[w] = 1'b0;
      tick();
      chk("rsvd_busy2", {31'd0, host_busy}, 32'd0);
      chk("rsvd_rel", {30'd0, grant}, 32'd0);
    end else begin
      chk("busy", {31'd0, host_busy}, 32'd1);
      if (drop_early) req_valid[w] = 1'b0;
      done_t  = (k <= TMO) ? k + 1 : TMO + 1;
      exp_err = (k <= TMO) ? herr : 1'b1;
      for (int t = 0; t < done_t; t++) begin
        if (t == k) begin
          host_done = 1'b1;
          host_err  = herr;
        end else if (!host_done) begin
          host_err = 1'($urandom_range(0, 1));
        end
        tick();
        if (t < done_t - 1) begin
          chk("wait_done", {30'd0, req_done}, 32'd0);
          chk("wait_cmd", {10'd0, host_cmd}, {10'd0, exp_cmd});
        end
      end
      chk("done", {30'd0, req_done}, {30'd0, oh});
      chk("err", {30'd0, req_err}, exp_err ? {30'd0, oh} : 32'd0);
      chk("busy_drop", {31'd0, host_busy}, 32'd0);
      chk("ack2", {31'd0, host_ack2}, 32'd1);
      req_valid[w] = 1'b0;
      if (host_done) begin
        for (int h = 0; h < hold; h++) begin
          tick();
          chk("hold_grant", {30'd0, grant}, {30'd0, oh});
          chk("hold_ack2", {31'd0, host_ack2}, 32'd1);
          chk("hold_done", {30'd0, req_done}, 32'd0);
        end
        host_done = 1'b0;
        host_err  = 1'b0;
      end
      tick();
      chk("rel_grant", {30'd0, grant}, 32'd0);
      chk("rel_ack2", {31'd0, host_ack2}, 32'd0);
    end
    last_served = w;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_op = '0;
    req_chs = '0;
    host_done = 1'b0;
    host_err = 1'b0;
    tick();
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Single READ, host answers after 10 cycles.
    present(0, 2'd1, 16'h0305);
    run_txn(10, 1'b0, 0, 1'b0);

    // Both requesters: alternation.
    for (int i = 0; i < 4; i++) begin
      if (!req_valid[0]) present(0, 2'd1, 16'(i * 3 + 1));
      if (!req_valid[1]) present(1, 2'd2, 16'(16'h8100 + i));
      run_txn(2, 1'b0, 0, 1'b0);
    end
    req_valid = 2'b00;
    tick();

    // Timeout, host never acknowledges.
    present(1, 2'd0, 16'h1234);
    run_txn(99, 1'b0, 0, 1'b0);

    // WRITE with host error, host_done held 5 cycles.
    present(0, 2'd2, 16'hABCD);
    run_txn(3, 1'b1, 5, 1'b0);

    // Reserved op.
    present(1, 2'd3, 16'h0F0F);
    run_txn(0, 1'b0, 0, 1'b0);

    // Stale ack in IDLE blocks the grant.
    host_done = 1'b1;
    present(0, 2'd1, 16'h0042);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stale_grant", {30'd0, grant}, 32'd0);
    end
    host_done = 1'b0;
    run_txn(1, 1'b0, 0, 1'b1);

    // Reset during WAIT_DONE.
    present(0, 2'd1, 16'h0707);
    present(1, 2'd1, 16'h0808);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk_all_zero("in_rst");
    rst_n = 1'b1;
    last_served = 1;
    run_txn(4, 1'b0, 1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && $urandom_range(0, 2) != 0)
          present(r, 2'($urandom_range(0, 3)), 16'($urandom));
      end
      if (req_valid == 2'b00)
        present(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                16'($urandom));
      run_txn(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
